iomem_arbiter: RTL and testbench
================================

// Module: iomem_arbiter
// PURPOSE
//  Two-master arbiter for the SoC peripheral bus (iomem valid/ready protocol).
//  Master 0 is the CPU iomem port; master 1 is a secondary bus master (e.g. DMA / sprite updater).
//  Grants the single downstream peripheral bus round-robin and holds the grant for one full transaction.
//  A watchdog ends hung transactions so neither master stalls forever.
// PARAMETERS
//  TIMEOUT_CYCLES  255          slave cycles allowed before forced completion (1..65535)
//  TIMEOUT_RDATA   32'hDEADBEEF rdata returned to the master on timeout
// PORTS
//  CLK          in   1   system clock
//  resetn       in   1   synchronous active-low reset
//  m0_valid     in   1   master 0 request
//  m0_ready     out  1   master 0 completion, one-cycle pulse
//  m0_wstrb     in   4   master 0 byte write strobes (0 = read)
//  m0_addr      in   32  master 0 address
//  m0_wdata     in   32  master 0 write data
//  m0_rdata     out  32  master 0 read data, valid while m0_ready=1
//  m1_*         -    -   identical set for master 1
//  s_valid      out  1   downstream request
//  s_ready      in   1   downstream completion
//  s_wstrb/s_addr/s_wdata  out 4/32/32  registered copy of granted master's request
//  s_rdata      in   32  downstream read data, sampled when s_ready=1
//  grant        out  1   master index owning the bus (valid while busy != 0)
//  busy         out  1   transaction in flight
//  timeout      out  1   one-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; last_grant=1 (so master 0 wins the first tie); counter 0.
//  States: IDLE -> REQ -> RESP -> IDLE.
//  IDLE: if exactly one mX_valid, grant it; if both, grant !last_grant. Capture addr/wdata/wstrb,
//   set s_valid=1, busy=1, grant, last_grant; go REQ. Nothing valid: stay.
//  REQ: s_valid held 1, request fields stable. Counter increments each cycle.
//   s_ready=1: latch s_rdata into granted mX_rdata, drop s_valid, go RESP.
//   counter==TIMEOUT_CYCLES-1 and s_ready=0: drop s_valid, rdata=TIMEOUT_RDATA, pulse timeout, go RESP.
//   s_ready and timeout in same cycle: s_ready wins, no timeout pulse.
//  RESP: granted mX_ready=1 for exactly one cycle; other master's ready stays 0;
//   counter cleared, busy=0 at exit; go IDLE.
//  Latency: request in IDLE at cycle t -> s_valid at t+1; s_ready at cycle k -> mX_ready at k+1.
//   Minimum round trip 3 cycles with 1-cycle slave.
//  Masters drop valid on the edge that sees ready; arbiter re-samples valids in IDLE only.
//  Non-granted master's request is held off (ready=0) until next IDLE; no request is ever dropped.
//  Master changing fields while waiting: ignored until granted (fields captured at grant).
//  Granted master dropping valid mid-transaction: transaction still completes downstream; ready pulse still issued.
//  s_ready while in IDLE or RESP: ignored.
//  Counter width ceil(log2(TIMEOUT_CYCLES+1)); never wraps (saturates at fire point).
//  resetn low mid-transaction: immediate return to reset state next edge; s_valid and readies drop, no pulse.
//  mX_rdata holds last value between transactions; only updated in REQ completion.
// TESTING
//  1 Reset, m0 read addr 32'h0300_0004, slave ready after 2 cycles with 32'h0000_00A5 -> m0_rdata=A5, m0_ready 1 cycle, s_valid 1 cycle after m0_valid.
//  2 m0 and m1 valid same cycle, repeated 4 times -> grants m0,m1,m0,m1; each sees exactly one ready pulse.
//  3 m1 write wstrb=4'hF wdata=32'h0014_001E to 32'h0500_0000 -> s_addr/s_wdata/s_wstrb match, stable until s_ready.
//  4 TIMEOUT_CYCLES=8, slave never ready -> timeout pulse and m0_ready after 8 REQ cycles, m0_rdata=32'hDEADBEEF, then next request serviced normally.
//  5 s_ready on exact timeout cycle -> slave data returned, timeout stays 0.
//  6 resetn low during REQ -> next cycle s_valid=0, busy=0, no ready pulse; after release m0 wins tie.

Source files
------------

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: two-master round-robin arbiter for the iomem valid/ready bus.
// It holds the grant for one full transaction, and a watchdog ends a slave that never answers.
module iomem_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic last_grant, to_hit, pick, fire, done, start;
  assign start = state == IDLE && (m0_valid || m1_valid);
  assign pick = (m0_valid && m1_valid) ? !last_grant : m1_valid;
  // s_ready has priority over the watchdog on the final cycle
  assign fire = state == REQ && !s_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done = state == REQ && s_ready;
  assign s_valid = state == REQ;
  assign busy = state != IDLE;
  assign m0_ready = state == RESP && !grant;
  assign m1_ready = state == RESP && grant;
  assign timeout = state == RESP && to_hit;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? REQ : IDLE) :
               state == REQ  ? ((done || fire) ? RESP : REQ) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state <= IDLE;
      last_grant <= 1'b1;
      grant <= 1'b0;
      cnt <= '0;
      to_hit <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        grant <= pick;
        last_grant <= pick;
        s_addr <= pick ? m1_addr : m0_addr;
        s_wdata <= pick ? m1_wdata : m0_wdata;
        s_wstrb <= pick ? m1_wstrb : m0_wstrb;
      end
      if (state == REQ) begin
        cnt <= fire ? cnt : cnt + 1'b1;
        to_hit <= fire;
      end
      if (state == RESP) cnt <= '0;
      if ((done || fire) && !grant) m0_rdata <= done ? s_rdata : TIMEOUT_RDATA;
      if ((done || fire) && grant) m1_rdata <= done ? s_rdata : TIMEOUT_RDATA;
    end
  end
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: directed and randomized transactions against a transaction-level model
// that tracks round-robin order, per-master read data and the watchdog outcome.
module tb_iomem_arbiter;
  logic CLK = 1'b0, resetn = 1'b0;
  logic [1:0] v;
  logic [31:0] a [2];
  logic [31:0] wd [2];
  logic [3:0] ws [2];
  logic s_ready;
  logic [31:0] s_rdata;
  logic m0_ready, m1_ready, s_valid, grant, busy, timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0] s_wstrb;
  int checks = 0, failures = 0;
  bit lg;
  logic [31:0] rd [2];
  always #5 CLK = ~CLK;
  iomem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .CLK(CLK), .resetn(resetn),
    .m0_valid(v[0]), .m0_ready(m0_ready), .m0_wstrb(ws[0]), .m0_addr(a[0]),
    .m0_wdata(wd[0]), .m0_rdata(m0_rdata),
    .m1_valid(v[1]), .m1_ready(m1_ready), .m1_wstrb(ws[1]), .m1_addr(a[1]),
    .m1_wdata(wd[1]), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .timeout(timeout)
  );
  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic check_idle();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_s_valid", s_valid, 1'b0);
    chk1("idle_m0_ready", m0_ready, 1'b0);
    chk1("idle_m1_ready", m1_ready, 1'b0);
    chk1("idle_timeout", timeout, 1'b0);
    chk32("idle_m0_rdata", m0_rdata, rd[0]);
    chk32("idle_m1_rdata", m1_rdata, rd[1]);
  endtask
  task automatic new_req(input int m);
    a[m] = $urandom;
    wd[m] = $urandom;
    ws[m] = 4'($urandom_range(0, 15));
    v[m] = 1'b1;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    v = 2'b00;
    s_ready = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    lg = 1'b1;
    rd[0] = '0;
    rd[1] = '0;
    @(negedge CLK);
  endtask
  // Entered at a negedge in IDLE with requests already driven; leaves at the next IDLE negedge.
  // lat = REQ cycle index on which the slave answers; lat > 7 means never (watchdog fires).
  task automatic txn(input int lat, input bit drop, input logic [31:0] data);
    bit w;
    logic [31:0] ea, ewd;
    logic [3:0] ews;
    w = (v[0] && v[1]) ? !lg : v[1];
    lg = w;
    ea = a[w];
    ewd = wd[w];
    ews = ws[w];
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      chk1("req_s_valid", s_valid, 1'b1);
      chk1("req_busy", busy, 1'b1);
      chk1("req_grant", grant, w);
      chk32("req_s_addr", s_addr, ea);
      chk32("req_s_wdata", s_wdata, ewd);
      chk32("req_s_wstrb", 32'(s_wstrb), 32'(ews));
      chk1("req_m0_ready", m0_ready, 1'b0);
      chk1("req_m1_ready", m1_ready, 1'b0);
      chk1("req_timeout", timeout, 1'b0);
      if (i == 0 && drop) v[w] = 1'b0;
      if (v[!w]) begin
        a[!w] = $urandom;
        wd[!w] = $urandom;
        ws[!w] = 4'($urandom_range(0, 15));
      end
      s_ready = (i == lat);
      s_rdata = (i == lat) ? data : $urandom;
      @(negedge CLK);
      if (i == lat) break;
    end
    s_ready = 1'b0;
    rd[w] = (lat <= 7) ? data : 32'hDEADBEEF;
    chk1("resp_m0_ready", m0_ready, !w);
    chk1("resp_m1_ready", m1_ready, w);
    chk1("resp_timeout", timeout, lat > 7);
    chk1("resp_busy", busy, 1'b1);
    chk1("resp_s_valid", s_valid, 1'b0);
    chk32("resp_m0_rdata", m0_rdata, rd[0]);
    chk32("resp_m1_rdata", m1_rdata, rd[1]);
    v[w] = 1'b0;
    @(negedge CLK);
    check_idle();
  endtask
  initial begin
    v = 2'b00;
    for (int m = 0; m < 2; m++) begin
      a[m] = '0;
      wd[m] = '0;
      ws[m] = '0;
      rd[m] = '0;
    end
    s_ready = 1'b0;
    s_rdata = '0;
    lg = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle();
    chk1("rst_grant", grant, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk32("rst_s_wdata", s_wdata, 32'h0);
    chk32("rst_s_wstrb", 32'(s_wstrb), 32'h0);
    resetn = 1'b1;
    @(negedge CLK);
    a[0] = 32'h0300_0004;
    wd[0] = '0;
    ws[0] = 4'h0;
    v[0] = 1'b1;
    txn(2, 1'b0, 32'h0000_00A5);
    chk32("t1_rdata", m0_rdata, 32'h0000_00A5);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (!v[0]) new_req(0);
      if (!v[1]) new_req(1);
      txn(0, 1'b0, $urandom);
    end
    txn(1, 1'b0, $urandom);
    a[1] = 32'h0500_0000;
    wd[1] = 32'h0014_001E;
    ws[1] = 4'hF;
    v[1] = 1'b1;
    txn(3, 1'b0, $urandom);
    new_req(0);
    txn(9, 1'b0, $urandom);
    chk32("t4_rdata", m0_rdata, 32'hDEADBEEF);
    new_req(0);
    txn(1, 1'b0, $urandom);
    new_req(0);
    txn(7, 1'b0, $urandom);
    s_ready = 1'b1;
    s_rdata = $urandom;
    @(negedge CLK);
    s_ready = 1'b0;
    check_idle();
    for (int k = 0; k < 60; k++) begin
      if (!v[0] && $urandom_range(0, 1) == 1) new_req(0);
      if (!v[1] && $urandom_range(0, 1) == 1) new_req(1);
      if (!v[0] && !v[1]) new_req(int'($urandom_range(0, 1)));
      txn(int'($urandom_range(0, 9)), $urandom_range(0, 3) == 0, $urandom);
    end
    if (v[0] || v[1]) txn(0, 1'b0, $urandom);
    new_req(0);
    @(negedge CLK);
    chk1("t6_s_valid_pre", s_valid, 1'b1);
    @(negedge CLK);
    resetn = 1'b0;
    v = 2'b00;
    @(negedge CLK);
    lg = 1'b1;
    rd[0] = '0;
    rd[1] = '0;
    check_idle();
    resetn = 1'b1;
    @(negedge CLK);
    new_req(0);
    new_req(1);
    txn(0, 1'b0, $urandom);
    chk1("t6_m1_waiting", v[1], 1'b1);
    txn(0, 1'b0, $urandom);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
